timer_cnt_src: RTL and testbench

TIMER_CNT_SRC -- requirements
Module: timer_cnt_src

---
 rtl/timer_cnt_src.sv | 110 +++++++++++
 tb/tb_timer_cnt_src.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_cnt_src.sv
// 8051-style timer/counter increment source: machine-cycle prescaler, pin synchronizers,
// Tx falling-edge detector and run gating that produce one-clk count requests.
module timer_cnt_src #(
  parameter int unsigned CLK_PER_MC  = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tr,
  input  logic gate,
  input  logic ct_sel,
  input  logic int_pin,
  input  logic t_pin,
  output logic mc_tick,
  output logic cnt_sig
);

  localparam int unsigned PW = (CLK_PER_MC > 1) ? $clog2(CLK_PER_MC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MC - 1);

  typedef enum logic [1:0] {
    ST_HI   = 2'd0,
    ST_FALL = 2'd1,
    ST_LO   = 2'd2
  } pin_state_t;

  logic [PW-1:0]          r_presc;
  logic [SYNC_STAGES-1:0] r_int_sync;
  logic [SYNC_STAGES-1:0] r_t_sync;
  pin_state_t             r_state;
  pin_state_t             w_state_nxt;
  logic                   r_mc_tick;
  logic                   r_cnt_sig;
  logic                   w_wrap;
  logic                   w_int_sync;
  logic                   w_t_sync;
  logic                   w_run;
  logic                   w_cnt_nxt;

  assign w_wrap     = (r_presc == PRESC_MAX);
  assign w_int_sync = r_int_sync[SYNC_STAGES-1];
  assign w_t_sync   = r_t_sync[SYNC_STAGES-1];
  assign w_run      = tr & (~gate | w_int_sync);

  // Free-running machine-cycle prescaler
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Pin synchronizers; reset to the idle-high level so reset cannot fabricate a prior low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_sync <= '1;
      r_t_sync   <= '1;
    end else begin
      r_int_sync <= {r_int_sync[SYNC_STAGES-2:0], int_pin};
      r_t_sync   <= {r_t_sync[SYNC_STAGES-2:0], t_pin};
    end
  end

  // Pin FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HI;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pin FSM next state: one sample per machine cycle
  always_comb begin
    w_state_nxt = r_state;
    if (w_wrap) begin
      case (r_state)
        ST_HI:   w_state_nxt = w_t_sync ? ST_HI : ST_FALL;
        ST_FALL: w_state_nxt = w_t_sync ? ST_HI : ST_LO;
        ST_LO:   w_state_nxt = w_t_sync ? ST_HI : ST_LO;
        default: w_state_nxt = ST_HI;
      endcase
    end
  end

  // Count request: every running machine cycle, or on leaving FALL in counter mode
  always_comb begin
    w_cnt_nxt = 1'b0;
    if (w_wrap && w_run) begin
      w_cnt_nxt = ct_sel ? (r_state == ST_FALL) : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mc_tick <= 1'b0;
      r_cnt_sig <= 1'b0;
    end else begin
      r_mc_tick <= w_wrap;
      r_cnt_sig <= w_cnt_nxt;
    end
  end

  assign mc_tick = r_mc_tick;
  assign cnt_sig = r_cnt_sig;

endmodule

// File: tb/tb_timer_cnt_src.sv
// Bench for timer_cnt_src: cycle-by-cycle comparison against a sample-history model,
// directed scenarios with literal pulse counts, then randomized pin/control activity.
module tb_timer_cnt_src;

  localparam int N = 12;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tr = 1'b1;
  logic gate = 1'b0;
  logic ct_sel = 1'b0;
  logic int_pin = 1'b1;
  logic t_pin = 1'b1;
  logic mc_tick;
  logic cnt_sig;

  always #5 clk = ~clk;

  timer_cnt_src #(.CLK_PER_MC(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .tr(tr), .gate(gate), .ct_sel(ct_sel),
    .int_pin(int_pin), .t_pin(t_pin), .mc_tick(mc_tick), .cnt_sig(cnt_sig)
  );

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;

  // Model: cycle position within machine cycle, delayed pin history, last two wrap samples
  bit   m_valid = 1'b0;
  int   m_presc = 0;
  logic m_tick = 1'b0;
  logic m_cnt = 1'b0;
  logic m_s1 = 1'b1;
  logic m_s2 = 1'b1;
  logic m_ts, m_is, m_wrap, m_run, m_edge;
  logic m_tq[$];
  logic m_iq[$];

  always @(posedge clk) begin
    if (rst) begin
      m_presc = 0;
      m_tick  = 1'b0;
      m_cnt   = 1'b0;
      m_s1    = 1'b1;
      m_s2    = 1'b1;
      m_tq.delete();
      m_iq.delete();
      for (int i = 0; i < S; i++) begin
        m_tq.push_back(1'b1);
        m_iq.push_back(1'b1);
      end
    end else begin
      m_ts   = m_tq[S-1];
      m_is   = m_iq[S-1];
      m_wrap = (m_presc == N - 1);
      m_run  = tr && (!gate || m_is);
      // a falling edge is pending when the latest sample is low and the one before was high
      m_edge = !m_s1 && m_s2;
      m_tick = m_wrap;
      m_cnt  = m_wrap && m_run && (ct_sel ? m_edge : 1'b1);
      if (m_wrap) begin
        m_s2 = m_s1;
        m_s1 = m_ts;
      end
      m_presc = (m_presc + 1) % N;
      m_tq.push_front(t_pin);
      m_iq.push_front(int_pin);
      void'(m_tq.pop_back());
      void'(m_iq.pop_back());
    end
    m_valid = 1'b1;
  end

  function automatic void chk_bit(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_int(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_le(string nm, int act, int maxv);
    n_chk++;
    if (act > maxv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected at most %0d at %0t", nm, act, maxv, $time);
    end
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk_bit("mc_tick", mc_tick, m_tick);
      chk_bit("cnt_sig", cnt_sig, m_cnt);
      chk_bit("cnt_outside_tick", cnt_sig & ~mc_tick, 1'b0);
      if (cnt_sig === 1'b1) pulses++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int k;

    // Reset held 3 clks with tr=1
    repeat (3) begin
      tick();
      chk_bit("reset_mc_tick", mc_tick, 1'b0);
      chk_bit("reset_cnt_sig", cnt_sig, 1'b0);
    end
    rst = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (mc_tick !== 1'b1 && k < 30);
    chk_int("first_mc_tick_latency", k, N);

    // Timer mode free run
    pulses = 0;
    repeat (10 * N) tick();
    chk_int("timer_mode_pulses", pulses, 10);

    // Gated off by INT low, then released
    gate = 1'b1;
    int_pin = 1'b0;
    repeat (N + S + 2) tick();
    pulses = 0;
    repeat (5 * N) tick();
    chk_int("gated_pulses", pulses, 0);
    int_pin = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (cnt_sig !== 1'b1 && k < 40);
    chk_le("gate_release_latency", k, S + N);
    pulses = 0;
    repeat (4 * N) tick();
    chk_int("gate_released_pulses", pulses, 4);

    // Counter mode: 48-clk square wave for 480 clks
    ct_sel = 1'b1;
    gate = 1'b0;
    t_pin = 1'b1;
    repeat (3 * N) tick();
    pulses = 0;
    for (int i = 0; i < 480; i++) begin
      t_pin = (((i / 24) % 2) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    chk_int("counter_mode_pulses", pulses, 10);

    // Short glitch placed between wrap edges
    t_pin = 1'b1;
    repeat (2 * N) tick();
    k = 0;
    while (m_presc != 1 && k < 2 * N) begin
      tick();
      k++;
    end
    pulses = 0;
    t_pin = 1'b0;
    repeat (3) tick();
    t_pin = 1'b1;
    repeat (4 * N) tick();
    chk_int("glitch_pulses", pulses, 0);

    // Long low level counts once
    pulses = 0;
    t_pin = 1'b0;
    repeat (40) tick();
    t_pin = 1'b1;
    repeat (4 * N) tick();
    chk_int("hold_pulses", pulses, 1);

    // Reset while an edge is pending; the first post-reset wrap must not count it
    t_pin = 1'b0;
    k = 0;
    while (!(!m_s1 && m_s2) && k < 3 * N) begin
      tick();
      k++;
    end
    chk_le("reach_fall_wait", k, 3 * N - 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulses = 0;
    repeat (20) tick();
    chk_int("reset_in_fall_pulses", pulses, 0);
    t_pin = 1'b1;
    repeat (3 * N) tick();

    // Randomized control and pin activity with occasional one-clk resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 599) == 0) rst = 1'b1;
      if ($urandom_range(0, 39) == 0) tr = 1'($urandom);
      if ($urandom_range(0, 49) == 0) gate = 1'($urandom);
      if ($urandom_range(0, 79) == 0) ct_sel = ~ct_sel;
      if ($urandom_range(0, 15) == 0) int_pin = ~int_pin;
      if ($urandom_range(0, 11) == 0) t_pin = ~t_pin;
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
